// File: rtl/cnn_stream_pkg.sv
// Shared types and constants for the CNN frame streamer.
package cnn_stream_pkg;

  localparam int PIXEL_W              = 8;
  localparam int CONF_W               = 8;
  localparam int FRAME_PIXELS_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_START       = 2'd1,
    ST_STREAM      = 2'd2,
    ST_WAIT_RESULT = 2'd3
  } stream_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding host pixel bytes until the frame streamer pops them.
// Push when full and pop when empty are ignored, so callers may gate loosely.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cnn_frame_streamer.sv
// Source end of the CNN pixel stream: buffers host bytes, streams one frame
// per request, then captures and holds the CNN result for the host.
module cnn_frame_streamer
  import cnn_stream_pkg::*;
#(
  parameter int FRAME_PIXELS   = FRAME_PIXELS_DEFAULT,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] host_data,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic               frame_go,
  output logic               frame_start,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_valid,
  input  logic               cnn_busy,
  input  logic               cnn_ready,
  input  logic               cnn_class,
  input  logic [CONF_W-1:0]  cnn_conf,
  output logic               result_class,
  output logic [CONF_W-1:0]  result_conf,
  output logic               result_valid,
  input  logic               result_ack,
  output logic               timeout,
  output logic               busy
);

  localparam int PC_W = $clog2(FRAME_PIXELS) + 1;
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FC_W = $clog2(FIFO_DEPTH + 1);

  stream_state_e      state_r;
  stream_state_e      state_next_s;
  logic [PC_W-1:0]    pix_cnt_r;
  logic [WC_W-1:0]    wait_cnt_r;
  logic [FC_W-1:0]    fifo_count_s;
  logic [PIXEL_W-1:0] fifo_head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               pop_s;
  logic               start_s;
  logic               capture_s;
  logic               timeout_hit_s;
  logic               last_pix_s;
  logic               frame_start_r;
  logic [PIXEL_W-1:0] pixel_out_r;
  logic               pixel_valid_r;
  logic               result_class_r;
  logic [CONF_W-1:0]  result_conf_r;
  logic               result_valid_r;
  logic               timeout_r;
  logic               busy_r;
  logic               cnn_busy_unused_s;

  // CNN busy status is observed by the host side only, never used for control.
  assign cnn_busy_unused_s = cnn_busy;

  assign host_ready = (fifo_count_s < FC_W'(FIFO_DEPTH)) & ~rst;
  assign push_s     = host_valid & ~fifo_full_s & ~rst;
  assign pop_s      = (state_r == ST_STREAM) & ~fifo_empty_s;
  assign last_pix_s = (pix_cnt_r == PC_W'(FRAME_PIXELS - 1));

  assign frame_start  = frame_start_r;
  assign pixel_out    = pixel_out_r;
  assign pixel_valid  = pixel_valid_r;
  assign result_class = result_class_r;
  assign result_conf  = result_conf_r;
  assign result_valid = result_valid_r;
  assign timeout      = timeout_r;
  assign busy         = busy_r;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIXEL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (host_data),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Next-state logic; a result arriving on the timeout cycle takes priority.
  always_comb begin
    state_next_s  = state_r;
    start_s       = 1'b0;
    capture_s     = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_go && !result_valid_r) begin
          state_next_s = ST_START;
          start_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_next_s = ST_STREAM;
      end
      ST_STREAM: begin
        if (pop_s && last_pix_s) begin
          state_next_s = ST_WAIT_RESULT;
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      ST_WAIT_RESULT: begin
        if (cnn_ready) begin
          capture_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else if (wait_cnt_r == WC_W'(TIMEOUT_CYCLES - 1)) begin
          // wait_cnt_r counts completed cycles, so this is cycle TIMEOUT_CYCLES
          timeout_hit_s = 1'b1;
          state_next_s  = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_RESULT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state plus the registered strobes derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      busy_r        <= (state_next_s != ST_IDLE);
      frame_start_r <= (state_next_s == ST_START);
    end
  end

  // Pixel output stage: each pop presents the FIFO head on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out_r   <= {PIXEL_W{1'b0}};
      pixel_valid_r <= 1'b0;
    end else begin
      pixel_valid_r <= pop_s;
      if (pop_s) begin
        pixel_out_r <= fifo_head_s;
      end else begin
        pixel_out_r <= pixel_out_r;
      end
    end
  end

  // Pixel and result-wait counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_r  <= {PC_W{1'b0}};
      wait_cnt_r <= {WC_W{1'b0}};
    end else begin
      if (start_s) begin
        pix_cnt_r <= {PC_W{1'b0}};
      end else if (pop_s) begin
        pix_cnt_r <= pix_cnt_r + PC_W'(1);
      end
      if (state_r == ST_WAIT_RESULT) begin
        wait_cnt_r <= wait_cnt_r + WC_W'(1);
      end else begin
        wait_cnt_r <= {WC_W{1'b0}};
      end
    end
  end

  // Result capture, host handshake and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_class_r <= 1'b0;
      result_conf_r  <= {CONF_W{1'b0}};
      result_valid_r <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      if (capture_s) begin
        result_class_r <= cnn_class;
        result_conf_r  <= cnn_conf;
        result_valid_r <= 1'b1;
      end else if (result_ack) begin
        result_valid_r <= 1'b0;
      end
      if (start_s) begin
        timeout_r <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Directed self-checking bench for cnn_frame_streamer.
module tb_cnn_frame_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] host_data = 8'd0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic       frame_go = 1'b0;
  logic       frame_start;
  logic [7:0] pixel_out;
  logic       pixel_valid;
  logic       cnn_busy = 1'b0;
  logic       cnn_ready = 1'b0;
  logic       cnn_class = 1'b0;
  logic [7:0] cnn_conf = 8'd0;
  logic       result_class;
  logic [7:0] result_conf;
  logic       result_valid;
  logic       result_ack = 1'b0;
  logic       timeout;
  logic       busy;

  int checks = 0;
  int passes = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int feed_gap   = 1;
  int feed_phase = 0;
  int pushed     = 0;
  int cyc        = 0;
  int first_pv   = -1;
  int last_pv    = -1;
  int fs_count   = 0;

  cnn_frame_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .host_data    (host_data),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .frame_go     (frame_go),
    .frame_start  (frame_start),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .cnn_busy     (cnn_busy),
    .cnn_ready    (cnn_ready),
    .cnn_class    (cnn_class),
    .cnn_conf     (cnn_conf),
    .result_class (result_class),
    .result_conf  (result_conf),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Host feeder: offers the queue head every feed_gap-th cycle.
  always @(negedge clk) begin
    if (tx_q.size() > 0 && feed_phase == 0) begin
      host_valid = 1'b1;
      host_data  = tx_q[0];
    end else begin
      host_valid = 1'b0;
    end
    feed_phase = (feed_phase + 1 >= feed_gap) ? 0 : feed_phase + 1;
  end

  // Handshake bookkeeping on the edge where the DUT samples the push.
  always @(posedge clk) begin
    if (host_valid && host_ready && !rst) begin
      void'(tx_q.pop_front());
      pushed++;
    end
  end

  // Output monitor sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (pixel_valid) begin
      rx_q.push_back(pixel_out);
      if (first_pv < 0) first_pv = cyc;
      last_pv = cyc;
    end
    if (frame_start) fs_count++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rx_q.delete();
    first_pv = -1;
    last_pv  = -1;
    fs_count = 0;
  endtask

  task automatic pulse_go();
    frame_go = 1'b1;
    @(negedge clk);
    frame_go = 1'b0;
  endtask

  task automatic send_result(input logic cls, input logic [7:0] conf);
    cnn_class = cls;
    cnn_conf  = conf;
    cnn_ready = 1'b1;
    @(negedge clk);
    cnn_ready = 1'b0;
  endtask

  task automatic pulse_ack();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (pixel_valid !== 1'b0) $display("FAIL reset_pixel_valid: got %b want 0", pixel_valid); else passes++;
    checks++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid: got %b want 0", result_valid); else passes++;
    checks++; if (host_ready !== 1'b0) $display("FAIL reset_host_ready: got %b want 0", host_ready); else passes++;
    checks++; if (result_conf !== 8'd0) $display("FAIL reset_result_conf: got %0d want 0", result_conf); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (host_ready !== 1'b1) $display("FAIL release_host_ready: got %b want 1", host_ready); else passes++;
    @(negedge clk);
  endtask

  task automatic test_stream_basic();
    bit ok;
    int bad = 0;
    clear_mon();
    feed_gap = 1;
    for (int i = 0; i < 64; i++) tx_q.push_back(8'(i));
    repeat (12) @(negedge clk);
    checks++; if (host_ready !== 1'b0) $display("FAIL basic_full: host_ready got %b want 0", host_ready); else passes++;
    pulse_go();
    checks++; if (frame_start !== 1'b1) $display("FAIL basic_frame_start: got %b want 1", frame_start); else passes++;
    checks++; if (pixel_valid !== 1'b0) $display("FAIL basic_early_pixel: got %b want 0", pixel_valid); else passes++;
    @(negedge clk);
    checks++; if (frame_start !== 1'b0) $display("FAIL basic_start_width: got %b want 0", frame_start); else passes++;
    wait_rx(64, 200, ok);
    checks++; if (!ok) $display("FAIL basic_pixels_arrive: got %0d want 64", rx_q.size()); else passes++;
    for (int i = 0; i < 64 && i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) bad++;
    checks++; if (bad != 0) $display("FAIL basic_pixel_data: %0d wrong values want 0", bad); else passes++;
    checks++; if (last_pv - first_pv + 1 != 64) $display("FAIL basic_consecutive: span %0d want 64", last_pv - first_pv + 1); else passes++;
    send_result(1'b1, 8'd85);
    checks++; if (result_valid !== 1'b1) $display("FAIL basic_result_valid: got %b want 1", result_valid); else passes++;
    checks++; if (result_class !== 1'b1) $display("FAIL basic_result_class: got %b want 1", result_class); else passes++;
    checks++; if (result_conf !== 8'd85) $display("FAIL basic_result_conf: got %0d want 85", result_conf); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy); else passes++;
    repeat (5) @(negedge clk);
    checks++; if (rx_q.size() != 64 || fs_count != 1) $display("FAIL basic_counts: pixels %0d starts %0d want 64 1", rx_q.size(), fs_count); else passes++;
  endtask

  task automatic test_go_blocked();
    fs_count = 0;
    pulse_go();
    repeat (3) @(negedge clk);
    checks++; if (fs_count != 0) $display("FAIL blocked_no_start: starts %0d want 0", fs_count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL blocked_busy: got %b want 0", busy); else passes++;
    pulse_ack();
    checks++; if (result_valid !== 1'b0) $display("FAIL ack_clears: got %b want 0", result_valid); else passes++;
    checks++; if (result_conf !== 8'd85 || result_class !== 1'b1) $display("FAIL ack_hold: got %b/%0d want 1/85", result_class, result_conf); else passes++;
  endtask

  task automatic test_stall();
    bit ok;
    int bad = 0;
    clear_mon();
    pulse_go();
    checks++; if (frame_start !== 1'b1) $display("FAIL stall_frame_start: got %b want 1", frame_start); else passes++;
    feed_gap = 3;
    for (int i = 0; i < 64; i++) tx_q.push_back(8'(64 + i));
    wait_rx(64, 400, ok);
    checks++; if (!ok) $display("FAIL stall_pixels_arrive: got %0d want 64", rx_q.size()); else passes++;
    for (int i = 0; i < 64 && i < rx_q.size(); i++) if (rx_q[i] !== 8'(64 + i)) bad++;
    checks++; if (bad != 0) $display("FAIL stall_pixel_data: %0d wrong values want 0", bad); else passes++;
    checks++; if (last_pv - first_pv + 1 <= 64) $display("FAIL stall_gaps: span %0d want >64", last_pv - first_pv + 1); else passes++;
    send_result(1'b0, 8'h3C);
    feed_gap = 1;
    checks++; if (result_valid !== 1'b1 || result_class !== 1'b0 || result_conf !== 8'h3C) $display("FAIL stall_result: got %b/%b/%h want 1/0/3c", result_valid, result_class, result_conf); else passes++;
    checks++; if (timeout !== 1'b0) $display("FAIL stall_timeout: got %b want 0", timeout); else passes++;
    repeat (4) @(negedge clk);
    checks++; if (rx_q.size() != 64) $display("FAIL stall_exact_count: got %0d want 64", rx_q.size()); else passes++;
    pulse_ack();
    send_result(1'b1, 8'h77);
    checks++; if (result_valid !== 1'b0 || result_conf !== 8'h3C) $display("FAIL idle_ready_ignored: got %b/%h want 0/3c", result_valid, result_conf); else passes++;
  endtask

  task automatic test_fifo_full();
    bit ok;
    int bad = 0;
    clear_mon();
    pushed = 0;
    for (int i = 0; i < 10; i++) tx_q.push_back(8'(100 + i));
    repeat (14) @(negedge clk);
    checks++; if (pushed != 8) $display("FAIL full_accepted: got %0d want 8", pushed); else passes++;
    checks++; if (host_ready !== 1'b0) $display("FAIL full_host_ready: got %b want 0", host_ready); else passes++;
    for (int i = 10; i < 64; i++) tx_q.push_back(8'(100 + i));
    pulse_go();
    wait_rx(64, 200, ok);
    checks++; if (!ok) $display("FAIL full_pixels_arrive: got %0d want 64", rx_q.size()); else passes++;
    for (int i = 0; i < 64 && i < rx_q.size(); i++) if (rx_q[i] !== 8'(100 + i)) bad++;
    checks++; if (bad != 0) $display("FAIL full_order: %0d wrong values want 0", bad); else passes++;
    send_result(1'b1, 8'd200);
    checks++; if (result_conf !== 8'd200) $display("FAIL full_result_conf: got %0d want 200", result_conf); else passes++;
    pulse_ack();
  endtask

  task automatic test_timeout();
    bit ok;
    int k = 0;
    clear_mon();
    for (int i = 0; i < 64; i++) tx_q.push_back(8'(i * 3));
    pulse_go();
    wait_rx(64, 200, ok);
    checks++; if (!ok) $display("FAIL to_pixels_arrive: got %0d want 64", rx_q.size()); else passes++;
    repeat (240) @(negedge clk);
    checks++; if (busy !== 1'b1 || timeout !== 1'b0) $display("FAIL to_early: busy %b timeout %b want 1 0", busy, timeout); else passes++;
    while (busy === 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++; if (timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", timeout); else passes++;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) $display("FAIL to_state: busy %b result_valid %b want 0 0", busy, result_valid); else passes++;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int bad = 0;
    clear_mon();
    for (int i = 0; i < 64; i++) tx_q.push_back(8'(i + 7));
    pulse_go();
    @(negedge clk);
    checks++; if (timeout !== 1'b0) $display("FAIL go_clears_timeout: got %b want 0", timeout); else passes++;
    wait_rx(30, 100, ok);
    checks++; if (!ok) $display("FAIL mid_pixels_arrive: got %0d want 30", rx_q.size()); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || pixel_valid !== 1'b0 || frame_start !== 1'b0) $display("FAIL mid_rst_ctrl: busy %b pv %b fs %b want 0 0 0", busy, pixel_valid, frame_start); else passes++;
    checks++; if (pixel_out !== 8'd0 || host_ready !== 1'b0 || result_conf !== 8'd0) $display("FAIL mid_rst_data: po %0d hr %b rc %0d want 0 0 0", pixel_out, host_ready, result_conf); else passes++;
    tx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    checks++; if (host_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_release: hr %b busy %b want 1 0", host_ready, busy); else passes++;
    pulse_go();
    repeat (10) @(negedge clk);
    checks++; if (rx_q.size() != 0) $display("FAIL mid_fifo_flushed: got %0d pixels want 0", rx_q.size()); else passes++;
    for (int i = 0; i < 64; i++) tx_q.push_back(8'(200 + i));
    wait_rx(64, 200, ok);
    checks++; if (!ok) $display("FAIL post_pixels_arrive: got %0d want 64", rx_q.size()); else passes++;
    for (int i = 0; i < 64 && i < rx_q.size(); i++) if (rx_q[i] !== 8'(200 + i)) bad++;
    checks++; if (bad != 0) $display("FAIL post_pixel_data: %0d wrong values want 0", bad); else passes++;
    send_result(1'b1, 8'hA5);
    repeat (4) @(negedge clk);
    checks++; if (rx_q.size() != 64) $display("FAIL post_exact_count: got %0d want 64", rx_q.size()); else passes++;
    checks++; if (result_valid !== 1'b1 || result_conf !== 8'hA5) $display("FAIL post_result: got %b/%h want 1/a5", result_valid, result_conf); else passes++;
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_go_blocked();
    test_stall();
    test_fifo_full();
    test_timeout();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
